// File: rtl/m92_pkg.sv
// Shared types for the ROM download word packer.
// FIFO entry layout, FSM encodings and default buffering depth.
package m92_pkg;

  localparam int DEF_FIFO_DEPTH = 4;

  typedef struct packed {
    logic [24:1] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } word_ent_t;

  typedef enum logic {
    P_EMPTY,
    P_HELD
  } pk_st_e;

  typedef enum logic {
    W_IDLE,
    W_BUSY
  } wr_st_e;

  function automatic word_ent_t part_word(
    input logic [24:1] a,
    input logic        lane,
    input logic [7:0]  b
  );
    word_ent_t e;
    e.addr = a;
    e.data = lane ? {b, 8'h00} : {8'h00, b};
    e.be   = lane ? 2'b10 : 2'b01;
    return e;
  endfunction

endpackage

// File: rtl/rom_word_fifo.sv
// Synchronous word FIFO between the byte packer and the SDRAM writer.
// Registered count and flags; a push to a full FIFO succeeds only alongside a pop.
module rom_word_fifo
  import m92_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  word_ent_t   data_i,
  input  logic        pop_i,
  output word_ent_t   data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        drop_o,
  output logic [AW:0] cnt_nxt_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  word_ent_t     mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          full_q;
  logic          empty_q;
  logic          push_ok;
  logic          pop_ok;

  assign pop_ok  = pop_i & ~empty_q;
  assign push_ok = push_i & (~full_q | pop_ok);
  assign drop_o  = push_i & ~push_ok;
  assign cnt_d   = cnt_q + (AW+1)'(push_ok)
                 - (AW+1)'(pop_ok);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == DEPTH_C);
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  assign data_o    = mem_q[rptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/rom_word_packer.sv
// Packs ioctl download bytes into 16-bit SDRAM words via a toggle handshake.
// Optional checksum outputs (csum, csum_valid) exist only with ROM_PACKER_CSUM_EN.
module rom_word_packer
  import m92_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int WAIT_THRESH = FIFO_DEPTH - 1
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic        ioctl_wait,
  output logic [24:0] sdr_addr,
  output logic [15:0] sdr_data,
  output logic [1:0]  sdr_be,
  output logic        sdr_req,
  input  logic        sdr_ack,
`ifdef ROM_PACKER_CSUM_EN
  output logic [15:0] csum,
  output logic        csum_valid,
`endif
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] THR = (AW+1)'(WAIT_THRESH);

  pk_st_e      pk_q, pk_d;
  wr_st_e      w_q, w_d;
  logic        downl_q;
  logic        dl_fall;
  logic        wr_acc;
  logic        pair_hit;
  logic [7:0]  held_byte_q;
  logic [24:1] held_addr_q;
  logic        held_lane_q;
  logic        push;
  logic        latch;
  word_ent_t   push_ent;
  word_ent_t   head;
  logic        pop;
  logic        pending;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_drop;
  logic [AW:0] fifo_cnt_nxt;
  logic [24:0] sdr_addr_q;
  logic [15:0] sdr_data_q;
  logic [1:0]  sdr_be_q;
  logic        sdr_req_q;
  logic        wait_q;
  logic        ovf_q;
  logic        busy_w;

  assign wr_acc   = ioctl_wr & ioctl_downl;
  assign dl_fall  = downl_q & ~ioctl_downl;
  assign pair_hit = (held_addr_q == ioctl_addr[24:1])
                  & (held_lane_q != ioctl_addr[0]);
  assign pending  = sdr_req_q ^ sdr_ack;

  rom_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i     (clk_sys),
    .rst_ni    (reset_n),
    .push_i    (push),
    .data_i    (push_ent),
    .pop_i     (pop),
    .data_o    (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .drop_o    (fifo_drop),
    .cnt_nxt_o (fifo_cnt_nxt)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      pk_q <= P_EMPTY;
      w_q  <= W_IDLE;
    end else begin
      pk_q <= pk_d;
      w_q  <= w_d;
    end
  end

  always_comb begin
    pk_d = pk_q;
    unique case (pk_q)
      P_EMPTY: if (wr_acc) pk_d = P_HELD;
      P_HELD: begin
        if ((wr_acc && pair_hit) || dl_fall)
          pk_d = P_EMPTY;
      end
    endcase
  end

  // Partial word is the default entry; a pair overrides data and be.
  always_comb begin
    push     = 1'b0;
    latch    = 1'b0;
    push_ent = part_word(held_addr_q, held_lane_q, held_byte_q);
    unique case (pk_q)
      P_EMPTY: latch = wr_acc;
      P_HELD: begin
        unique case (1'b1)
          wr_acc && pair_hit: begin
            push          = 1'b1;
            push_ent.be   = 2'b11;
            push_ent.data = held_lane_q
                          ? {held_byte_q, ioctl_data}
                          : {ioctl_data, held_byte_q};
          end
          wr_acc && !pair_hit: begin
            push  = 1'b1;
            latch = 1'b1;
          end
          dl_fall: push = 1'b1;
          default: ;
        endcase
      end
    endcase
  end

  always_comb begin
    w_d = w_q;
    unique case (w_q)
      W_IDLE: if (!fifo_empty && !pending) w_d = W_BUSY;
      W_BUSY: if (!pending) w_d = W_IDLE;
    endcase
  end

  always_comb begin
    pop    = (w_q == W_IDLE) & ~fifo_empty & ~pending;
    busy_w = (pk_q == P_HELD) | ~fifo_empty | pending;
  end

  // Reset re-aligns sdr_req to sdr_ack, abandoning any open request.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      downl_q     <= 1'b0;
      held_byte_q <= '0;
      held_addr_q <= '0;
      held_lane_q <= 1'b0;
      sdr_addr_q  <= '0;
      sdr_data_q  <= '0;
      sdr_be_q    <= '0;
      sdr_req_q   <= sdr_ack;
      wait_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      downl_q <= ioctl_downl;
      if (latch) begin
        held_byte_q <= ioctl_data;
        held_addr_q <= ioctl_addr[24:1];
        held_lane_q <= ioctl_addr[0];
      end
      if (pop) begin
        sdr_addr_q <= {head.addr, 1'b0};
        sdr_data_q <= head.data;
        sdr_be_q   <= head.be;
        sdr_req_q  <= ~sdr_req_q;
      end
      wait_q <= (fifo_cnt_nxt >= THR);
      ovf_q  <= ovf_q | fifo_drop;
    end
  end

  assign ioctl_wait = wait_q;
  assign sdr_addr   = sdr_addr_q;
  assign sdr_data   = sdr_data_q;
  assign sdr_be     = sdr_be_q;
  assign sdr_req    = sdr_req_q;
  assign busy       = busy_w;

`ifdef ROM_PACKER_CSUM_EN
  logic        dl_rise;
  logic [15:0] csum_q, csum_d;
  logic        cval_q, cval_d;
  logic        fell_q, fell_d;

  assign dl_rise = ~downl_q & ioctl_downl;

  always_comb begin
    csum_d = dl_rise ? 16'h0000 : csum_q;
    if (wr_acc) csum_d = csum_d + {8'h00, ioctl_data};
    fell_d = dl_rise ? 1'b0 : (fell_q | dl_fall);
    cval_d = dl_rise ? 1'b0 : (cval_q | (fell_q & ~busy_w));
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      csum_q <= '0;
      cval_q <= 1'b0;
      fell_q <= 1'b0;
    end else begin
      csum_q <= csum_d;
      cval_q <= cval_d;
      fell_q <= fell_d;
    end
  end

  assign csum       = csum_q;
  assign csum_valid = cval_q;
`endif

endmodule

// File: doc/rom_word_packer.md
ROM_WORD_PACKER -- requirements
Module: rom_word_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of packed-word entries buffered toward SDRAM (power of two, 2..16).
REQ-002 SHALL have parameter WAIT_THRESH, default FIFO_DEPTH-1, occupancy at or above which ioctl_wait asserts.
REQ-003 SHALL have port clk_sys, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port ioctl_downl, input, 1, download window active.
REQ-006 SHALL have port ioctl_wr, input, 1, one-cycle byte strobe.
REQ-007 SHALL have port ioctl_addr, input, 25, byte address of ioctl_data.
REQ-008 SHALL have port ioctl_data, input, 8, byte payload.
REQ-009 SHALL have port ioctl_wait, output, 1, backpressure to the download source.
REQ-010 SHALL have port sdr_addr, output, 25, byte address of the word; bit 0 always 0.
REQ-011 SHALL have port sdr_data, output, 16, packed word; even byte in [7:0], odd byte in [15:8].
REQ-012 SHALL have port sdr_be, output, 2, byte enables; bit0 = [7:0], bit1 = [15:8].
REQ-013 SHALL have port sdr_req, output, 1, toggle request toward the SDRAM port.
REQ-014 SHALL have port sdr_ack, input, 1, toggle acknowledge; a request is pending while sdr_req != sdr_ack.
REQ-015 SHALL have port busy, output, 1, high while a held byte, FIFO entry or pending request exists.

Function
REQ-016 Packer states: EMPTY (no held byte) and HELD (one byte latched, with address and lane).
REQ-017 EMPTY + ioctl_wr: latch the byte, its word address ioctl_addr[24:1] and lane ioctl_addr[0]; go to HELD.
REQ-018 HELD + ioctl_wr, same word address, opposite lane: push the full word with be=2'b11; go to EMPTY.
REQ-019 HELD + ioctl_wr, different word or same lane: push the held byte as a partial word (be=01 for even, 10 for odd), then latch the new byte; stay in HELD.
REQ-020 On the falling edge of ioctl_downl while in HELD: push the held partial word; go to EMPTY.
REQ-021 Each push writes one FIFO entry {addr, data, be} in the same cycle; case REQ-019 needs one push only.
REQ-022 Writer states: W_IDLE and W_BUSY.
REQ-023 W_IDLE with FIFO non-empty and no pending request: pop an entry onto sdr_addr/sdr_data/sdr_be, toggle sdr_req, go to W_BUSY.
REQ-024 In W_BUSY, sdr_addr/data/be SHALL hold stable; when sdr_ack == sdr_req, go to W_IDLE. The next pop occurs no earlier than the following cycle.
REQ-025 ioctl_wait SHALL be registered and high when FIFO occupancy >= WAIT_THRESH; the threshold leaves one spare slot for the byte strobed in the same cycle.
REQ-026 A push to a full FIFO is a protocol violation; the packer SHALL drop the byte and set sticky flag ovf. ovf is visible in simulation only and is not a port.
REQ-027 A simultaneous push and pop on the same cycle SHALL leave occupancy unchanged.
REQ-028 Order SHALL be preserved: words reach SDRAM in ioctl byte order.
REQ-029 ioctl_wr while ioctl_downl = 0 SHALL be ignored.

Reset
REQ-030 While reset_n = 0 at a clock edge: packer goes to EMPTY, writer to W_IDLE, FIFO is emptied, sdr_req <= sdr_ack, ioctl_wait = 0, busy = 0, sdr_addr = 0, sdr_data = 0, sdr_be = 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the pending request without toggling sdr_req again.

Configuration
REQ-032 With macro ROM_PACKER_CSUM_EN defined, the module SHALL add outputs csum[15:0], a running modulo-2^16 sum of accepted bytes cleared on the rising edge of ioctl_downl, and csum_valid, high from the cycle after the FIFO drains post-download until the next rising edge of ioctl_downl.
REQ-033 Without ROM_PACKER_CSUM_EN, those ports and that logic SHALL be absent.

Structure
REQ-034 The FIFO entry struct typedef (addr[24:1], data[15:0], be[1:0]) and the default depth constant SHALL live in m92_pkg.
REQ-035 The FIFO SHALL be the sub-module rom_word_fifo (synchronous, registered count, full/empty flags); packer and writer FSMs stay in rom_word_packer.

Verification
REQ-036 The bench SHALL cover: bytes 0x11@0, 0x22@1 -> one write, addr 0x0, data 0x2211, be 11.
REQ-037 The bench SHALL cover: bytes 0xAA@4, 0xBB@9, then download end -> writes (0x4, 0x00AA, be 01), (0x8, 0xBB00, be 10).
REQ-038 The bench SHALL cover: 16 back-to-back bytes with sdr_ack delayed 20 cycles -> ioctl_wait high at occupancy 3, no ovf, 8 ordered words.
REQ-039 The bench SHALL cover: reset_n low for 1 cycle while in W_BUSY -> FIFO empty, busy 0, sdr_req == sdr_ack afterwards.
REQ-040 The bench SHALL cover: odd-length download of 5 bytes 0x01..0x05 -> last write be=01, data 0x0005; with ROM_PACKER_CSUM_EN, csum = 0x000F and csum_valid asserts.
REQ-041 The bench SHALL cover: ioctl_wr with ioctl_downl = 0 -> no FIFO push, sdr_req unchanged.
